// File: rtl/fetch_controller_if.sv
// Fetch-side bundle: instruction memory request/ack channel plus the decode presentation channel.
// Handshakes: imem_req/imem_addr hold until imem_ack; an instruction is consumed when instr_valid=1 and stall=0.
interface fetch_controller_if;
    logic        stall;
    logic        branch_valid;
    logic [31:0] branch_offset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;

    modport master (
        input  stall, branch_valid, branch_offset, imem_ack, imem_rdata,
        output imem_req, imem_addr, instr_valid, instr, instr_pc
    );

    modport slave (
        output stall, branch_valid, branch_offset, imem_ack, imem_rdata,
        input  imem_req, imem_addr, instr_valid, instr, instr_pc
    );
endinterface

// File: rtl/fetch_controller.sv
// Instruction fetch controller: single outstanding request, 1-entry skid buffer,
// branch redirect with squash of in-flight words. state_dbg exposes the FSM (0=REQ, 1=HOLD).
module fetch_controller #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                rst_n,
    fetch_controller_if.master  bus,
    output logic                state_dbg
);

    typedef enum logic {
        REQ  = 1'b0,
        HOLD = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] instr_pc_q, instr_pc_d;
    logic        valid_q, valid_d;
    logic [31:0] skid_data_q, skid_data_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic        redir_q, redir_d;
    logic [31:0] redir_pc_q, redir_pc_d;

    logic        consume;
    logic        slot_free;
    logic        branch;
    logic [31:0] target;

    assign consume   = valid_q & ~bus.stall;
    assign slot_free = ~valid_q | consume;
    assign branch    = consume & bus.branch_valid;
    assign target    = instr_pc_q + 32'd4 + (bus.branch_offset << 2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= REQ;
            fetch_pc_q  <= RESET_PC;
            instr_q     <= 32'd0;
            instr_pc_q  <= 32'd0;
            valid_q     <= 1'b0;
            skid_data_q <= 32'd0;
            skid_pc_q   <= 32'd0;
            redir_q     <= 1'b0;
            redir_pc_q  <= 32'd0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            instr_q     <= instr_d;
            instr_pc_q  <= instr_pc_d;
            valid_q     <= valid_d;
            skid_data_q <= skid_data_d;
            skid_pc_q   <= skid_pc_d;
            redir_q     <= redir_d;
            redir_pc_q  <= redir_pc_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        instr_d     = instr_q;
        instr_pc_d  = instr_pc_q;
        valid_d     = valid_q;
        skid_data_d = skid_data_q;
        skid_pc_d   = skid_pc_q;
        redir_d     = redir_q;
        redir_pc_d  = redir_pc_q;

        // A consumed slot empties unless a new word is loaded below.
        if (consume) begin
            valid_d = 1'b0;
        end

        case (state_q)
            REQ: begin
                if (branch) begin
                    if (bus.imem_ack) begin
                        fetch_pc_d = target;
                    end else begin
                        // Request must stay stable until acked; retarget once it completes.
                        redir_d    = 1'b1;
                        redir_pc_d = target;
                    end
                end else if (bus.imem_ack) begin
                    if (redir_q) begin
                        fetch_pc_d = redir_pc_q;
                        redir_d    = 1'b0;
                    end else if (slot_free) begin
                        instr_d    = bus.imem_rdata;
                        instr_pc_d = fetch_pc_q;
                        valid_d    = 1'b1;
                        fetch_pc_d = fetch_pc_q + 32'd4;
                    end else begin
                        skid_data_d = bus.imem_rdata;
                        skid_pc_d   = fetch_pc_q;
                        fetch_pc_d  = fetch_pc_q + 32'd4;
                        state_d     = HOLD;
                    end
                end
            end
            HOLD: begin
                if (branch) begin
                    fetch_pc_d = target;
                    state_d    = REQ;
                end else if (consume) begin
                    instr_d    = skid_data_q;
                    instr_pc_d = skid_pc_q;
                    valid_d    = 1'b1;
                    state_d    = REQ;
                end
            end
            default: begin
                state_d = REQ;
            end
        endcase
    end

    assign bus.imem_req    = (state_q == REQ);
    assign bus.imem_addr   = fetch_pc_q;
    assign bus.instr_valid = valid_q;
    assign bus.instr       = instr_q;
    assign bus.instr_pc    = instr_pc_q;
    assign state_dbg       = state_q;

endmodule

// File: tb/tb_fetch_controller.sv
// Bench for fetch_controller: directed scenarios plus randomized stall/ack/branch traffic,
// checked by a scoreboard that follows the architectural instruction stream.
module tb_fetch_controller;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic state_dbg;

    int errors = 0;
    int checks = 0;
    int consumes = 0;
    logic [63:0] exp_q[$];
    logic [31:0] mon_pc;
    logic [31:0] mon_nxt;

    fetch_controller_if bus();

    fetch_controller #(.RESET_PC(RESET_PC)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return {addr[15:0], ~addr[31:16]} ^ 32'h5A3C_96E1;
    endfunction

    // Memory model: data is only meaningful on ack cycles.
    assign bus.imem_rdata = bus.imem_ack ? mem_word(bus.imem_addr) : (32'hBAD0_BAD0 ^ bus.imem_addr);

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: the presented word must be the head of the expected stream.
    always @(negedge clk) begin
        if (rst_n && bus.instr_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_empty: got pc 0x%08h expected no instruction", bus.instr_pc);
            end else begin
                check32("sb_pc", bus.instr_pc, exp_q[0][63:32]);
                check32("sb_instr", bus.instr, exp_q[0][31:0]);
                if (!bus.stall) begin
                    mon_pc = exp_q[0][63:32];
                    if (bus.branch_valid)
                        mon_nxt = mon_pc + 32'd4 + (bus.branch_offset << 2);
                    else
                        mon_nxt = mon_pc + 32'd4;
                    void'(exp_q.pop_front());
                    exp_q.push_back({mon_nxt, mem_word(mon_nxt)});
                    consumes++;
                end
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check1({tag, "_req"}, bus.imem_req, 1'b1);
        check32({tag, "_addr"}, bus.imem_addr, RESET_PC);
        check1({tag, "_valid"}, bus.instr_valid, 1'b0);
        check32({tag, "_instr"}, bus.instr, 32'd0);
        check32({tag, "_pc"}, bus.instr_pc, 32'd0);
        check1({tag, "_state"}, state_dbg, 1'b0);
    endtask

    task automatic do_reset(input string tag);
        bus.stall         = 1'b0;
        bus.branch_valid  = 1'b0;
        bus.branch_offset = 32'd0;
        bus.imem_ack      = 1'b0;
        rst_n             = 1'b0;
        exp_q.delete();
        exp_q.push_back({RESET_PC, mem_word(RESET_PC)});
        #1;
        check_reset_outputs(tag);
        repeat (2) @(posedge clk);
        #1;
        check32({tag, "_addr_held"}, bus.imem_addr, RESET_PC);
        rst_n = 1'b1;
    endtask

    task automatic wait_pc(input logic [31:0] pc);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 64 && !found; i++) begin
            @(posedge clk);
            #1;
            found = bus.instr_valid && (bus.instr_pc == pc);
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL wait_pc: got no instr_pc 0x%08h expected within 64 cycles", pc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int off;
        int base;
        bus.stall         = 1'b0;
        bus.branch_valid  = 1'b0;
        bus.branch_offset = 32'd0;
        bus.imem_ack      = 1'b0;
        #2;

        // Straight-line streaming, one instruction per cycle.
        do_reset("t1_rst");
        bus.imem_ack = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            check1("t1_valid", bus.instr_valid, 1'b1);
            check32("t1_pc", bus.instr_pc, 32'(k * 4));
        end

        // Stall at 0x8: one word parks in the skid, request drops.
        do_reset("t2_rst");
        bus.imem_ack = 1'b1;
        wait_pc(32'h8);
        bus.stall = 1'b1;
        repeat (3) step();
        check1("t2_hold", state_dbg, 1'b1);
        check1("t2_req", bus.imem_req, 1'b0);
        check32("t2_pc_held", bus.instr_pc, 32'h8);
        check1("t2_valid_held", bus.instr_valid, 1'b1);
        bus.stall = 1'b0;
        step();
        check1("t2_valid_c", bus.instr_valid, 1'b1);
        check32("t2_pc_c", bus.instr_pc, 32'hC);
        step();
        check32("t2_pc_10", bus.instr_pc, 32'h10);

        // Branch with ack in the same cycle.
        do_reset("t3_rst");
        bus.imem_ack = 1'b1;
        wait_pc(32'h10);
        bus.branch_valid  = 1'b1;
        bus.branch_offset = 32'd3;
        step();
        bus.branch_valid  = 1'b0;
        bus.branch_offset = 32'd0;
        check1("t3_squash", bus.instr_valid, 1'b0);
        check32("t3_addr", bus.imem_addr, 32'h20);
        step();
        check1("t3_valid", bus.instr_valid, 1'b1);
        check32("t3_pc", bus.instr_pc, 32'h20);

        // Backward branch while the request is still outstanding.
        do_reset("t4_rst");
        bus.imem_ack = 1'b1;
        wait_pc(32'h10);
        bus.branch_valid  = 1'b1;
        bus.branch_offset = 32'hFFFF_FFFB;
        bus.imem_ack      = 1'b0;
        step();
        bus.branch_valid  = 1'b0;
        bus.branch_offset = 32'd0;
        check1("t4_squash", bus.instr_valid, 1'b0);
        check1("t4_req", bus.imem_req, 1'b1);
        check32("t4_addr_hold1", bus.imem_addr, 32'h14);
        step();
        check32("t4_addr_hold2", bus.imem_addr, 32'h14);
        bus.imem_ack = 1'b1;
        step();
        check1("t4_dropped", bus.instr_valid, 1'b0);
        check32("t4_addr_redir", bus.imem_addr, 32'h0);
        step();
        check1("t4_valid", bus.instr_valid, 1'b1);
        check32("t4_pc", bus.instr_pc, 32'h0);

        // Branch from the top of the address space wraps to zero.
        do_reset("t5_rst");
        bus.imem_ack = 1'b1;
        wait_pc(32'h0);
        bus.branch_valid  = 1'b1;
        bus.branch_offset = 32'hFFFF_FFFE;
        step();
        bus.branch_valid  = 1'b0;
        bus.branch_offset = 32'd0;
        wait_pc(32'hFFFF_FFFC);
        bus.branch_valid = 1'b1;
        step();
        bus.branch_valid = 1'b0;
        check1("t5_squash", bus.instr_valid, 1'b0);
        check32("t5_addr", bus.imem_addr, 32'h0);
        step();
        check32("t5_pc", bus.instr_pc, 32'h0);

        // Reset while the skid is full, then while a request is pending.
        do_reset("t6_rst");
        bus.imem_ack = 1'b1;
        wait_pc(32'h8);
        bus.stall = 1'b1;
        step();
        check1("t6_hold", state_dbg, 1'b1);
        #2;
        do_reset("t6_mid_hold");
        bus.imem_ack = 1'b1;
        step();
        check32("t6_first_pc", bus.instr_pc, RESET_PC);
        check32("t6_first_instr", bus.instr, mem_word(RESET_PC));
        wait_pc(32'h8);
        bus.stall    = 1'b1;
        bus.imem_ack = 1'b0;
        step();
        #2;
        do_reset("t6_mid_req");
        bus.imem_ack = 1'b1;
        step();
        check32("t6_req_pc", bus.instr_pc, RESET_PC);

        // Randomized traffic, with one reset in the middle.
        do_reset("rnd_rst");
        base = consumes;
        for (int i = 0; i < 3000; i++) begin
            step();
            if (i == 1500) begin
                #2;
                do_reset("rnd_mid_rst");
            end
            bus.stall        = ($urandom_range(0, 3) == 0);
            bus.imem_ack     = ($urandom_range(0, 2) != 0);
            bus.branch_valid = ($urandom_range(0, 4) == 0);
            off = int'($urandom_range(0, 40)) - 20;
            bus.branch_offset = off;
        end
        checks++;
        if (consumes - base < 300) begin
            errors++;
            $display("FAIL rnd_progress: got %0d consumed expected at least 300", consumes - base);
        end
        bus.stall        = 1'b1;
        bus.branch_valid = 1'b0;
        bus.imem_ack     = 1'b0;
        repeat (2) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
